// File: rtl/eep_pkg.sv
// Shared types and packing constants for the EEPROM host bridge.
package eep_pkg;

   localparam int unsigned BYTES_PER_WORD = 4;
   localparam int unsigned LANE_W         = $clog2(BYTES_PER_WORD);
   localparam int unsigned WORD_W         = 8 * BYTES_PER_WORD;

   typedef enum logic [2:0] {
      StIdle,
      StRdIssue,
      StRdCap,
      StRdPush,
      StLdWait,
      StLdWr,
      StFinish
   } state_e;

   // One-hot lane select for a byte position inside a packed word.
   function automatic logic [BYTES_PER_WORD-1:0] lane_sel(input logic [LANE_W-1:0] lane);
      logic [BYTES_PER_WORD-1:0] sel;
      sel       = '0;
      sel[lane] = 1'b1;
      return sel;
   endfunction

endpackage

// File: rtl/eep_host_bridge_if.sv
// Host save/load streams plus the EEPROM external-access port.
interface eep_host_bridge_if
   import eep_pkg::*;
#(
   parameter int unsigned ADDR_W = 17
);

   logic [WORD_W-1:0] dump_data;
   logic              dump_valid;
   logic              dump_ready;
   logic [WORD_W-1:0] load_data;
   logic              load_valid;
   logic              load_ready;
   logic [ADDR_W-1:0] eep_addr;
   logic [7:0]        eep_wdata;
   logic              eep_wr;
   logic              eep_rd;
   logic              eep_en;
   logic [7:0]        eep_rdata;

   // Bridge side.
   modport master (
      output dump_data, dump_valid, load_ready,
      output eep_addr, eep_wdata, eep_wr, eep_rd, eep_en,
      input  dump_ready, load_data, load_valid, eep_rdata
   );

   // Host and EEPROM side.
   modport slave (
      input  dump_data, dump_valid, load_ready,
      input  eep_addr, eep_wdata, eep_wr, eep_rd, eep_en,
      output dump_ready, load_data, load_valid, eep_rdata
   );

endinterface

// File: rtl/eep_word_pack.sv
// Four-byte lane register: packs read bytes into a word, or holds a host word for unpacking.
module eep_word_pack
   import eep_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              i_load_word,
   input  logic [WORD_W-1:0] i_word,
   input  logic              i_cap_byte,
   input  logic [LANE_W-1:0] i_cap_lane,
   input  logic [7:0]        i_byte,
   input  logic [LANE_W-1:0] i_rd_lane,
   output logic [WORD_W-1:0] o_word,
   output logic [7:0]        o_byte
);

   logic [BYTES_PER_WORD-1:0][7:0] r_lanes;
   logic [BYTES_PER_WORD-1:0]      w_sel;

   assign w_sel = lane_sel(i_cap_lane);

   // Whole-word load wins over a single-lane capture.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_lanes <= '0;
      end else if (i_load_word) begin
         r_lanes <= i_word;
      end else if (i_cap_byte) begin
         for (int i = 0; i < BYTES_PER_WORD; i++) begin
            if (w_sel[i]) r_lanes[i] <= i_byte;
         end
      end
   end

   assign o_word = r_lanes;
   assign o_byte = r_lanes[i_rd_lane];

endmodule

// File: rtl/eep_host_bridge.sv
// Moves the whole EEPROM image between the array and the 32-bit host save/load streams.
module eep_host_bridge
   import eep_pkg::*;
#(
   parameter int unsigned EEP_SIZE = 1024,
   parameter int unsigned ADDR_W   = 17
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_start_dump,
   input  logic              i_start_load,
   input  logic              i_abort,
   output logic              o_busy,
   output logic              o_done,
   eep_host_bridge_if.master bus
);

   localparam int unsigned           CNT_W    = $clog2(EEP_SIZE);
   localparam logic [CNT_W-1:0]      LAST     = CNT_W'(EEP_SIZE - 1);
   localparam logic [LANE_W-1:0]     TOP_LANE = LANE_W'(BYTES_PER_WORD - 1);

   state_e             r_state;
   logic [CNT_W-1:0]   r_addr;
   logic               r_busy;
   logic               r_done;
   logic               r_dump_valid;
   logic               r_load_ready;
   logic               r_eep_wr;
   logic               r_eep_rd;
   logic               r_eep_en;
   logic [7:0]         r_eep_wdata;

   logic [LANE_W-1:0]  w_lane;
   logic [LANE_W-1:0]  w_next_lane;
   logic               w_last;
   logic               w_load_hs;
   logic               w_cap;
   logic [WORD_W-1:0]  w_pack_word;
   logic [7:0]         w_pack_byte;

   assign w_lane      = r_addr[LANE_W-1:0];
   assign w_next_lane = w_lane + LANE_W'(1);
   assign w_last      = (r_addr == LAST);
   assign w_load_hs   = (r_state == StLdWait) && bus.load_valid && r_load_ready;
   assign w_cap       = (r_state == StRdCap);

   // Same lane register packs on dump and unpacks on load; dump_data is its content.
   eep_word_pack u_pack (
      .clk         (clk),
      .rst         (rst),
      .i_load_word (w_load_hs),
      .i_word      (bus.load_data),
      .i_cap_byte  (w_cap),
      .i_cap_lane  (w_lane),
      .i_byte      (bus.eep_rdata),
      .i_rd_lane   (w_next_lane),
      .o_word      (w_pack_word),
      .o_byte      (w_pack_byte)
   );

   // Transfer sequencer; every output is a register set on the transition into a state.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= StIdle;
         r_addr       <= '0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_dump_valid <= 1'b0;
         r_load_ready <= 1'b0;
         r_eep_wr     <= 1'b0;
         r_eep_rd     <= 1'b0;
         r_eep_en     <= 1'b0;
         r_eep_wdata  <= '0;
      end else if (i_abort && (r_state != StIdle)) begin
         // Partially written words are left as they are.
         r_state      <= StIdle;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_dump_valid <= 1'b0;
         r_load_ready <= 1'b0;
         r_eep_wr     <= 1'b0;
         r_eep_rd     <= 1'b0;
         r_eep_en     <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            StIdle: begin
               if (i_start_dump) begin
                  r_addr   <= '0;
                  r_busy   <= 1'b1;
                  r_eep_en <= 1'b1;
                  r_eep_rd <= 1'b1;
                  r_state  <= StRdIssue;
               end else if (i_start_load) begin
                  r_addr       <= '0;
                  r_busy       <= 1'b1;
                  r_eep_en     <= 1'b1;
                  r_load_ready <= 1'b1;
                  r_state      <= StLdWait;
               end
            end
            StRdIssue: r_state <= StRdCap;
            StRdCap: begin
               if (w_lane == TOP_LANE) begin
                  // Stop reading while the word waits for the host.
                  r_dump_valid <= 1'b1;
                  r_eep_rd     <= 1'b0;
                  r_state      <= StRdPush;
               end else begin
                  r_addr  <= r_addr + CNT_W'(1);
                  r_state <= StRdIssue;
               end
            end
            StRdPush: begin
               if (bus.dump_ready) begin
                  r_dump_valid <= 1'b0;
                  if (w_last) begin
                     r_done   <= 1'b1;
                     r_busy   <= 1'b0;
                     r_eep_en <= 1'b0;
                     r_state  <= StFinish;
                  end else begin
                     r_addr   <= r_addr + CNT_W'(1);
                     r_eep_rd <= 1'b1;
                     r_state  <= StRdIssue;
                  end
               end
            end
            StLdWait: begin
               if (w_load_hs) begin
                  // Lane 0 comes straight from the bus; the pack register fills this edge.
                  r_load_ready <= 1'b0;
                  r_eep_wr     <= 1'b1;
                  r_eep_wdata  <= bus.load_data[7:0];
                  r_state      <= StLdWr;
               end
            end
            StLdWr: begin
               if (w_lane == TOP_LANE) begin
                  r_eep_wr <= 1'b0;
                  if (w_last) begin
                     r_done   <= 1'b1;
                     r_busy   <= 1'b0;
                     r_eep_en <= 1'b0;
                     r_state  <= StFinish;
                  end else begin
                     r_addr       <= r_addr + CNT_W'(1);
                     r_load_ready <= 1'b1;
                     r_state      <= StLdWait;
                  end
               end else begin
                  r_addr      <= r_addr + CNT_W'(1);
                  r_eep_wdata <= w_pack_byte;
               end
            end
            StFinish: r_state <= StIdle;
            default:  r_state <= StIdle;
         endcase
      end
   end

   assign o_busy         = r_busy;
   assign o_done         = r_done;
   assign bus.dump_data  = w_pack_word;
   assign bus.dump_valid = r_dump_valid;
   assign bus.load_ready = r_load_ready;
   assign bus.eep_addr   = {{(ADDR_W - CNT_W){1'b0}}, r_addr};
   assign bus.eep_wdata  = r_eep_wdata;
   assign bus.eep_wr     = r_eep_wr;
   assign bus.eep_rd     = r_eep_rd;
   assign bus.eep_en     = r_eep_en;

endmodule

// File: tb/tb_eep_host_bridge.sv
// Directed bench for eep_host_bridge with a 16-byte EEPROM model.
module tb_eep_host_bridge;

   localparam int unsigned EEP_SIZE = 16;
   localparam int unsigned ADDR_W   = 17;

   typedef struct {
      int stall_word;
      int stall_n;
      bit both;
      bit mid_load;
   } dump_vec_t;

   typedef struct {
      logic [31:0]      word;
      int               gap;
      logic [3:0][7:0]  exp;
   } load_vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start_dump = 1'b0;
   logic start_load = 1'b0;
   logic abort = 1'b0;
   logic busy;
   logic done;

   logic       pre_load = 1'b0;
   logic       cnt_clr  = 1'b0;
   logic [7:0] mem [EEP_SIZE];
   int         wr_cnt, rd_cnt, done_cnt;
   bit         lr_seen;

   int          n_chk = 0;
   int          n_err = 0;
   logic [31:0] got [8];
   int          got_n;
   logic [31:0] exp_words [4];
   dump_vec_t   dvec [4];
   load_vec_t   lvec [4];

   always #5 clk = ~clk;

   eep_host_bridge_if #(.ADDR_W(ADDR_W)) bus ();

   eep_host_bridge #(
      .EEP_SIZE (EEP_SIZE),
      .ADDR_W   (ADDR_W)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .i_start_dump (start_dump),
      .i_start_load (start_load),
      .i_abort      (abort),
      .o_busy       (busy),
      .o_done       (done),
      .bus          (bus)
   );

   // EEPROM model and event counters.
   always @(posedge clk) begin
      if (pre_load) begin
         for (int i = 0; i < EEP_SIZE; i++) mem[i] <= 8'(i);
      end else if (bus.eep_en && bus.eep_wr) begin
         mem[bus.eep_addr[3:0]] <= bus.eep_wdata;
      end
      if (bus.eep_en && bus.eep_rd) bus.eep_rdata <= mem[bus.eep_addr[3:0]];
      if (cnt_clr) begin
         wr_cnt   <= 0;
         rd_cnt   <= 0;
         done_cnt <= 0;
         lr_seen  <= 1'b0;
      end else begin
         if (bus.eep_en && bus.eep_wr) wr_cnt <= wr_cnt + 1;
         if (bus.eep_en && bus.eep_rd) rd_cnt <= rd_cnt + 1;
         if (done) done_cnt <= done_cnt + 1;
         if (bus.load_ready) lr_seen <= 1'b1;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_done"}, 32'(done), 32'd0);
      chk({tag, "_dump_valid"}, 32'(bus.dump_valid), 32'd0);
      chk({tag, "_load_ready"}, 32'(bus.load_ready), 32'd0);
      chk({tag, "_eep_en"}, 32'(bus.eep_en), 32'd0);
      chk({tag, "_eep_rd"}, 32'(bus.eep_rd), 32'd0);
      chk({tag, "_eep_wr"}, 32'(bus.eep_wr), 32'd0);
      chk({tag, "_eep_addr"}, 32'(bus.eep_addr), 32'd0);
      chk({tag, "_eep_wdata"}, 32'(bus.eep_wdata), 32'd0);
      chk({tag, "_dump_data"}, bus.dump_data, 32'd0);
   endtask

   task automatic clear_counts();
      cnt_clr = 1'b1;
      @(negedge clk);
      cnt_clr = 1'b0;
   endtask

   task automatic do_dump(input dump_vec_t v, input string tag);
      int cyc;
      int stall_left;
      int rd_snap;
      clear_counts();
      got_n      = 0;
      stall_left = v.stall_n;
      rd_snap    = 0;
      bus.dump_ready = 1'b1;
      start_dump = 1'b1;
      start_load = v.both;
      @(negedge clk);
      start_dump = 1'b0;
      start_load = 1'b0;
      cyc = 0;
      while (done_cnt == 0 && cyc < 300) begin
         start_load = (v.mid_load && cyc == 10);
         if (bus.dump_valid && got_n == v.stall_word && stall_left > 0) begin
            bus.dump_ready = 1'b0;
            if (stall_left == v.stall_n) rd_snap = rd_cnt;
            chk({tag, "_stall_data"}, bus.dump_data, exp_words[v.stall_word]);
            chk({tag, "_stall_no_read"}, 32'(rd_cnt), 32'(rd_snap));
            stall_left--;
         end else begin
            bus.dump_ready = 1'b1;
         end
         if (bus.dump_valid && bus.dump_ready) begin
            if (got_n < 8) got[got_n] = bus.dump_data;
            got_n++;
         end
         @(negedge clk);
         cyc++;
      end
      start_load = 1'b0;
      chk({tag, "_finished"}, 32'(done_cnt > 0), 32'd1);
      chk({tag, "_busy_after"}, 32'(busy), 32'd0);
      repeat (4) @(negedge clk);
      chk({tag, "_word_count"}, 32'(got_n), 32'd4);
      for (int i = 0; i < 4; i++) chk({tag, "_word"}, got[i], exp_words[i]);
      chk({tag, "_done_once"}, 32'(done_cnt), 32'd1);
      if (v.both || v.mid_load) chk({tag, "_no_load_ready"}, 32'(lr_seen), 32'd0);
   endtask

   initial begin
      int t;
      exp_words[0] = 32'h0302_0100;
      exp_words[1] = 32'h0706_0504;
      exp_words[2] = 32'h0B0A_0908;
      exp_words[3] = 32'h0F0E_0D0C;
      dvec[0] = '{stall_word: -1, stall_n: 0, both: 1'b0, mid_load: 1'b0};
      dvec[1] = '{stall_word:  1, stall_n: 5, both: 1'b0, mid_load: 1'b0};
      dvec[2] = '{stall_word: -1, stall_n: 0, both: 1'b1, mid_load: 1'b0};
      dvec[3] = '{stall_word: -1, stall_n: 0, both: 1'b0, mid_load: 1'b1};
      lvec[0] = '{word: 32'hDEAD_BEEF, gap: 3, exp: {8'hDE, 8'hAD, 8'hBE, 8'hEF}};
      lvec[1] = '{word: 32'h1122_3344, gap: 3, exp: {8'h11, 8'h22, 8'h33, 8'h44}};
      lvec[2] = '{word: 32'h5566_7788, gap: 3, exp: {8'h55, 8'h66, 8'h77, 8'h88}};
      lvec[3] = '{word: 32'h99AA_BBCC, gap: 3, exp: {8'h99, 8'hAA, 8'hBB, 8'hCC}};

      bus.dump_ready = 1'b1;
      bus.load_valid = 1'b0;
      bus.load_data  = '0;
      pre_load = 1'b1;
      cnt_clr  = 1'b1;
      repeat (3) @(negedge clk);
      pre_load = 1'b0;
      cnt_clr  = 1'b0;
      chk_reset("reset");
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 4; i++) do_dump(dvec[i], $sformatf("dump%0d", i));

      // Abort while word 2 is being read.
      clear_counts();
      got_n = 0;
      bus.dump_ready = 1'b1;
      start_dump = 1'b1;
      @(negedge clk);
      start_dump = 1'b0;
      t = 0;
      while (got_n < 2 && t < 200) begin
         if (bus.dump_valid) got_n++;
         @(negedge clk);
         t++;
      end
      chk("abort_reach_word2", 32'(got_n), 32'd2);
      repeat (2) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_eep_en", 32'(bus.eep_en), 32'd0);
      chk("abort_dump_valid", 32'(bus.dump_valid), 32'd0);
      chk("abort_eep_rd", 32'(bus.eep_rd), 32'd0);
      repeat (20) @(negedge clk);
      chk("abort_no_done", 32'(done_cnt), 32'd0);
      do_dump(dvec[0], "post_abort");

      // Load four words with gaps.
      clear_counts();
      start_load = 1'b1;
      @(negedge clk);
      start_load = 1'b0;
      for (int i = 0; i < 4; i++) begin
         repeat (lvec[i].gap) @(negedge clk);
         bus.load_valid = 1'b1;
         bus.load_data  = lvec[i].word;
         t = 0;
         while (!bus.load_ready && t < 100) begin
            @(negedge clk);
            t++;
         end
         chk("load_ready_seen", 32'(bus.load_ready), 32'd1);
         @(negedge clk);
         bus.load_valid = 1'b0;
      end
      t = 0;
      while (done_cnt == 0 && t < 100) begin
         @(negedge clk);
         t++;
      end
      repeat (4) @(negedge clk);
      chk("load_done_once", 32'(done_cnt), 32'd1);
      chk("load_wr_pulses", 32'(wr_cnt), 32'd16);
      chk("load_busy_after", 32'(busy), 32'd0);
      for (int i = 0; i < 4; i++) begin
         for (int b = 0; b < 4; b++) begin
            chk($sformatf("load_mem%0d", 4 * i + b), 32'(mem[4 * i + b]), 32'(lvec[i].exp[b]));
         end
      end

      // Reset while byte 2 of the first word is on the bus.
      pre_load = 1'b1;
      @(negedge clk);
      pre_load = 1'b0;
      clear_counts();
      start_load = 1'b1;
      @(negedge clk);
      start_load = 1'b0;
      bus.load_valid = 1'b1;
      bus.load_data  = 32'hCAFE_F00D;
      t = 0;
      while (!(bus.eep_wr && bus.eep_addr == ADDR_W'(2)) && t < 50) begin
         @(negedge clk);
         t++;
      end
      chk("rst_reach_byte2", 32'(bus.eep_wr), 32'd1);
      rst = 1'b1;
      bus.load_valid = 1'b0;
      @(negedge clk);
      chk_reset("rst_mid");
      rst = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_mem0", 32'(mem[0]), 32'h0D);
      chk("rst_mem1", 32'(mem[1]), 32'hF0);
      chk("rst_mem2", 32'(mem[2]), 32'hFE);
      chk("rst_mem3_untouched", 32'(mem[3]), 32'h03);
      chk("rst_wr_pulses", 32'(wr_cnt), 32'd3);
      chk("rst_no_done", 32'(done_cnt), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
